// File: rtl/bm_rd_arbiter.sv
// -----------------------------------------------------------------------------
// bm_rd_arbiter
//
// Shares the single Bias Memory read port among NR requesters. Each cycle one
// requester is granted by round-robin. The BM read is issued from a register
// on the next cycle. A {valid, requester} tag pipeline follows every read
// through the fixed BM latency, so returned data and a one-hot valid can be
// routed back to the requester that asked for them.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   req          per-requester read request (bit i = requester i)
//   req_addr     flattened read addresses, slice [i*AW +: AW] = requester i
//   gnt          one-hot grant, combinational from req and the rr pointer
//   bm_rd_en     BM read enable (registered)
//   bm_rd_addr   BM read address (registered, holds when idle)
//   bm_dout      BM read data
//   bm_dout_vld  BM read data valid, RD_LAT cycles after bm_rd_en
//   rd_dout      returned data broadcast to all requesters (registered)
//   rd_dout_vld  one-hot return valid (registered)
//   busy         high while any read is in flight
//   err_tag      sticky flag: BM return did not line up with the tag pipeline
// -----------------------------------------------------------------------------
`ifndef BM_DEPTH
`define BM_DEPTH 1024
`endif
`ifndef BM_DATA_WIDTH
`define BM_DATA_WIDTH 32
`endif

module bm_rd_arbiter #(
    parameter int NR     = 2,
    parameter int AW     = $clog2(`BM_DEPTH),
    parameter int DW     = `BM_DATA_WIDTH,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    req,
    input  logic [NR*AW-1:0] req_addr,
    output logic [NR-1:0]    gnt,
    output logic             bm_rd_en,
    output logic [AW-1:0]    bm_rd_addr,
    input  logic [DW-1:0]    bm_dout,
    input  logic             bm_dout_vld,
    output logic [DW-1:0]    rd_dout,
    output logic [NR-1:0]    rd_dout_vld,
    output logic             busy,
    output logic             err_tag
);

    localparam int IW = (NR > 1) ? $clog2(NR) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic [IW-1:0]     issue_idx;
    logic [RD_LAT-1:0] tag_vld;
    logic [IW-1:0]     tag_idx [RD_LAT];
    logic [CW-1:0]     ign_cnt;
    logic              ignore;
    logic              head_vld;
    logic [IW-1:0]     head_idx;
    logic [NR-1:0]     head_onehot;
    logic              ret_ok;
    logic              mismatch;

    // Round-robin scan starting at rr_ptr; first requester found wins.
    always_comb begin : arb
        int cand;
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        gnt_any = 1'b0;
        gnt_idx = rr_ptr;
        cand    = 0;
        for (int o = 0; o < NR; o++) begin
            cand = int'(rr_ptr) + o;
            if (cand >= NR) cand = cand - NR;
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
        if (rst) gnt_any = 1'b0;
    end

    always_comb begin
        gnt = '0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    // The last tag stage lines up with bm_dout_vld. After a reset, reads
    // already inside the BM pipeline still come back for RD_LAT cycles; those
    // returns belong to discarded requests and are silently dropped.
    assign ignore   = (ign_cnt != '0);
    assign head_vld = tag_vld[RD_LAT-1];
    assign head_idx = tag_idx[RD_LAT-1];
    assign ret_ok   = !ignore && bm_dout_vld && head_vld;
    assign mismatch = !ignore && (bm_dout_vld != head_vld);
    assign busy     = bm_rd_en | (|tag_vld);

    always_comb begin
        head_onehot = '0;
        head_onehot[head_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            bm_rd_en    <= 1'b0;
            bm_rd_addr  <= '0;
            issue_idx   <= '0;
            tag_vld     <= '0;
            for (int s = 0; s < RD_LAT; s++) tag_idx[s] <= '0;
            ign_cnt     <= CW'(RD_LAT);
            rd_dout     <= '0;
            rd_dout_vld <= '0;
            err_tag     <= 1'b0;
        end else begin
            bm_rd_en <= gnt_any;
            if (gnt_any) begin
                bm_rd_addr <= req_addr[gnt_idx*AW +: AW];
                issue_idx  <= gnt_idx;
                rr_ptr     <= (int'(gnt_idx) == NR - 1) ? '0 : gnt_idx + 1'b1;
            end

            // Tag stage 0 is loaded one cycle after bm_rd_en so that stage
            // RD_LAT-1 coincides with bm_dout_vld.
            tag_vld[0] <= bm_rd_en;
            tag_idx[0] <= issue_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end

            if (ignore) ign_cnt <= ign_cnt - 1'b1;

            rd_dout_vld <= '0;
            if (ret_ok) begin
                rd_dout     <= bm_dout;
                rd_dout_vld <= head_onehot;
            end

            if (mismatch) err_tag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bm_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bm_rd_arbiter
//
// Drives bm_rd_arbiter (NR=2, RD_LAT=2) against a behavioural BM with a fixed
// two-cycle read pipeline. Each cycle the bench applies one stimulus record
// carrying the expected grant; expected returns are queued at grant time and
// compared when they fall due.
// -----------------------------------------------------------------------------
module tb_bm_rd_arbiter;

    localparam int NR     = 2;
    localparam int AW     = 8;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]    gnt;
    logic             bm_rd_en;
    logic [AW-1:0]    bm_rd_addr;
    logic [DW-1:0]    bm_dout;
    logic             bm_dout_vld;
    logic [DW-1:0]    rd_dout;
    logic [NR-1:0]    rd_dout_vld;
    logic             busy;
    logic             err_tag;
    logic             spur;

    always #5 clk = ~clk;

    bm_rd_arbiter #(.NR(NR), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .bm_rd_en    (bm_rd_en),
        .bm_rd_addr  (bm_rd_addr),
        .bm_dout     (bm_dout),
        .bm_dout_vld (bm_dout_vld),
        .rd_dout     (rd_dout),
        .rd_dout_vld (rd_dout_vld),
        .busy        (busy),
        .err_tag     (err_tag)
    );

    // Behavioural BM: contents are a fixed function of the address.
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {a ^ 8'hC3, ~a};
    endfunction

    logic          bm_v [RD_LAT];
    logic [AW-1:0] bm_a [RD_LAT];

    always @(posedge clk) begin
        bm_v[0] <= bm_rd_en;
        bm_a[0] <= bm_rd_addr;
        for (int s = 1; s < RD_LAT; s++) begin
            bm_v[s] <= bm_v[s-1];
            bm_a[s] <= bm_a[s-1];
        end
    end

    assign bm_dout_vld = bm_v[RD_LAT-1] | spur;
    assign bm_dout     = mem_data(bm_a[RD_LAT-1]);

    // Scoreboard and bookkeeping
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } ret_t;

    typedef struct {
        logic [NR-1:0] req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [NR-1:0] gnt;
    } vec_t;

    ret_t          sb [$];
    vec_t          vecs [$];
    int            cyc    = 0;
    int            passed = 0;
    int            total  = 0;
    logic          exp_en = 1'b0;
    logic [AW-1:0] exp_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        else
            passed++;
    endtask

    function automatic void add(input logic [NR-1:0] r, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic [NR-1:0] g);
        vec_t v;
        v.req = r; v.a0 = a0; v.a1 = a1; v.gnt = g;
        vecs.push_back(v);
    endfunction

    // One clock cycle: apply inputs, check grant, issue and return, then
    // queue the expected return of this cycle's grant.
    task automatic tick(input logic r, input logic [NR-1:0] rq, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [NR-1:0] eg, input logic sp);
        logic [NR-1:0] exp_vld;
        int            idx;
        ret_t          e;
        @(posedge clk);
        #1;
        cyc++;
        rst      = r;
        req      = rq;
        req_addr = {a1, a0};
        spur     = sp;
        #1;
        check("gnt", 32'(gnt), 32'(eg));
        check("bm_rd_en", 32'(bm_rd_en), 32'(exp_en));
        check("bm_rd_addr", 32'(bm_rd_addr), 32'(exp_addr));

        exp_vld = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e       = sb.pop_front();
            exp_vld = NR'(1) << e.idx;
            check("rd_dout", 32'(rd_dout), 32'(e.data));
        end
        check("rd_dout_vld", 32'(rd_dout_vld), 32'(exp_vld));

        if (r) begin
            sb.delete();
            exp_en   = 1'b0;
            exp_addr = '0;
        end else begin
            exp_en = (eg != '0);
            if (eg != '0) begin
                idx      = eg[1] ? 1 : 0;
                exp_addr = (idx == 1) ? a1 : a0;
                e.due    = cyc + 2 + RD_LAT;
                e.idx    = idx;
                e.data   = mem_data(exp_addr);
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_addr = '0; spur = 1'b0;

        // Single request, contention 0,1,0,1,0,1, pointer hold while idle.
        add(2'b00, 8'd0, 8'd0,  2'b00);
        add(2'b01, 8'd5, 8'd0,  2'b01);
        for (int k = 0; k < 4; k++) add(2'b00, 8'd0, 8'd0, 2'b00);
        add(2'b10, 8'd0, 8'd9,  2'b10);
        add(2'b11, 8'd1, 8'd20, 2'b01);
        add(2'b11, 8'd2, 8'd20, 2'b10);
        add(2'b11, 8'd2, 8'd21, 2'b01);
        add(2'b11, 8'd3, 8'd21, 2'b10);
        add(2'b11, 8'd3, 8'd22, 2'b01);
        add(2'b11, 8'd4, 8'd22, 2'b10);
        add(2'b01, 8'd4, 8'd0,  2'b01);
        add(2'b00, 8'd0, 8'd0,  2'b00);
        add(2'b00, 8'd0, 8'd0,  2'b00);
        add(2'b11, 8'd7, 8'd8,  2'b10);
        add(2'b01, 8'd7, 8'd0,  2'b01);
        for (int k = 0; k < 5; k++) add(2'b00, 8'd0, 8'd0, 2'b00);

        repeat (2) @(posedge clk);

        // Reset: grant suppressed while rst is high, outputs cleared.
        tick(1'b1, 2'b11, 8'd3, 8'd4, 2'b00, 1'b0);
        tick(1'b0, 2'b00, 8'd0, 8'd0, 2'b00, 1'b0);
        check("rst_rd_dout", 32'(rd_dout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_tag", 32'(err_tag), 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            tick(1'b0, vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].gnt, 1'b0);

        // Streaming: requester 1 alone, addresses 0..15 back to back.
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 2'b10, 8'd0, AW'(i), 2'b10, 1'b0);
            if (i > 0) check("busy_stream", 32'(busy), 32'd1);
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            idle(1);
            if (sb.size() > 0) check("busy_drain", 32'(busy), 32'd1);
        end
        idle(1);
        check("busy_fall", 32'(busy), 32'd0);

        // Fairness: requester 0 continuous, requester 1 joins late.
        for (int i = 0; i < 4; i++) tick(1'b0, 2'b01, AW'(30 + i), 8'd0, 2'b01, 1'b0);
        tick(1'b0, 2'b11, 8'd34, 8'd40, 2'b10, 1'b0);
        tick(1'b0, 2'b11, 8'd34, 8'd40, 2'b01, 1'b0);
        tick(1'b0, 2'b01, 8'd35, 8'd0,  2'b01, 1'b0);
        idle(6);

        // Reset with three reads in flight.
        tick(1'b0, 2'b01, 8'd50, 8'd0, 2'b01, 1'b0);
        tick(1'b0, 2'b01, 8'd51, 8'd0, 2'b01, 1'b0);
        tick(1'b0, 2'b01, 8'd52, 8'd0, 2'b01, 1'b0);
        tick(1'b1, 2'b00, 8'd0,  8'd0, 2'b00, 1'b0);
        idle(1);
        check("mid_rst_rd_dout", 32'(rd_dout), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err_tag", 32'(err_tag), 32'd0);
        idle(1);
        check("mid_rst_err_tag2", 32'(err_tag), 32'd0);
        tick(1'b0, 2'b11, 8'd60, 8'd61, 2'b01, 1'b0);
        idle(6);
        check("post_rst_err_tag", 32'(err_tag), 32'd0);

        // Spurious BM valid with nothing outstanding.
        tick(1'b0, 2'b00, 8'd0, 8'd0, 2'b00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("err_tag_sticky", 32'(err_tag), 32'd1);
        end
        tick(1'b1, 2'b00, 8'd0, 8'd0, 2'b00, 1'b0);
        idle(1);
        check("err_tag_clear", 32'(err_tag), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
